// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with hold, settle, flush and timeout
module fetch_unit #(
   parameter int unsigned TIMEOUT = 16,
   parameter logic [7:0]  JMP_OP  = 8'h40,
   parameter logic [7:0]  BR_OP   = 8'h41
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  add,
   output logic        mem_req,
   output logic [7:0]  mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   input  logic        dec_ready,
   input  logic        zflag,
   input  logic        flush,
   output logic [15:0] ir,
   output logic        ir_valid,
   output logic        pc_en,
   output logic [7:0]  im,
   output logic        branch,
   output logic        nia,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HOLD   = 2'd2,
      SETTLE = 2'd3
   } state_t;

   // Last wait count before the request is considered lost.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic        ir_valid_q, ir_valid_d;
   logic        pc_en_q, pc_en_d;
   logic        fetch_err_q, fetch_err_d;
   logic [7:0]  wait_q, wait_d;

   // Next-state logic; flush overrides every other event, ir keeps its stale value.
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      ir_valid_d  = ir_valid_q;
      pc_en_d     = pc_en_q;
      fetch_err_d = fetch_err_q;
      wait_d      = wait_q;
      if (flush) begin
         state_d    = FETCH;
         ir_valid_d = 1'b0;
         pc_en_d    = 1'b0;
         wait_d     = 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = FETCH;
               wait_d  = 8'd0;
            end
            FETCH: begin
               if (mem_ack) begin
                  ir_d       = mem_rdata;
                  ir_valid_d = 1'b1;
                  state_d    = HOLD;
               end else if (wait_q == WAIT_LAST) begin
                  // Flag the timeout and keep requesting the same address.
                  fetch_err_d = 1'b1;
                  wait_d      = 8'd0;
               end else begin
                  wait_d = wait_q + 8'd1;
               end
            end
            HOLD: begin
               if (dec_ready) begin
                  ir_valid_d = 1'b0;
                  pc_en_d    = 1'b1;
                  state_d    = SETTLE;
               end
            end
            SETTLE: begin
               // One cycle for the PC to advance before the next request.
               pc_en_d = 1'b0;
               state_d = FETCH;
               wait_d  = 8'd0;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ir_q        <= 16'h0000;
         ir_valid_q  <= 1'b0;
         pc_en_q     <= 1'b0;
         fetch_err_q <= 1'b0;
         wait_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         ir_valid_q  <= ir_valid_d;
         pc_en_q     <= pc_en_d;
         fetch_err_q <= fetch_err_d;
         wait_q      <= wait_d;
      end
   end

   // Memory request and combinational decode of the instruction register.
   always_comb begin
      mem_req   = (state_q == FETCH);
      mem_addr  = add;
      ir        = ir_q;
      ir_valid  = ir_valid_q;
      pc_en     = pc_en_q;
      fetch_err = fetch_err_q;
      im        = ir_q[7:0];
      nia       = (ir_q[15:8] != JMP_OP);
      branch    = (ir_q[15:8] == BR_OP) & zflag;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  add;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        dec_ready;
   logic        zflag;
   logic        flush;
   logic [15:0] ir;
   logic        ir_valid;
   logic        pc_en;
   logic [7:0]  im;
   logic        branch;
   logic        nia;
   logic        fetch_err;

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_ir;

   fetch_unit #(.TIMEOUT(4), .JMP_OP(8'h40), .BR_OP(8'h41)) dut (
      .clk(clk), .rst(rst), .add(add), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dec_ready(dec_ready), .zflag(zflag),
      .flush(flush), .ir(ir), .ir_valid(ir_valid), .pc_en(pc_en), .im(im),
      .branch(branch), .nia(nia), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ir_valid();
      for (int i = 0; i < 8 && ir_valid !== 1'b1; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; add = 8'h05; mem_ack = 1'b0; mem_rdata = 16'h0; dec_ready = 1'b0;
      zflag = 1'b0; flush = 1'b0;
      tick(); tick();
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req act=%b exp=0", mem_req); end
      checks++; if (ir !== 16'h0000) begin failures++; $display("FAIL reset_ir act=%h exp=0000", ir); end
      checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL reset_ir_valid act=%b exp=0", ir_valid); end
      checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL reset_pc_en act=%b exp=0", pc_en); end
      checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL reset_fetch_err act=%b exp=0", fetch_err); end
      checks++; if ({im, nia, branch} !== {8'h00, 1'b1, 1'b0}) begin failures++; $display("FAIL reset_decode act=%h/%b/%b exp=00/1/0", im, nia, branch); end
   endtask

   task automatic test_fetch();
      rst = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL first_cycle_mem_req act=%b exp=0", mem_req); end
      tick();
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL second_cycle_mem_req act=%b exp=1", mem_req); end
      checks++; if (mem_addr !== 8'h05) begin failures++; $display("FAIL fetch_mem_addr act=%h exp=05", mem_addr); end
      tick();
      checks++; if (mem_req !== 1'b1 || ir_valid !== 1'b0) begin failures++; $display("FAIL fetch_wait act=%b/%b exp=1/0", mem_req, ir_valid); end
      tick();
      mem_ack = 1'b1; mem_rdata = 16'h1234; exp_q.push_back(16'h1234);
      tick();
      mem_ack = 1'b0;
      wait_ir_valid();
      checks++;
      if (ir_valid !== 1'b1 || exp_q.size() == 0) begin failures++; $display("FAIL fetch_ir_valid act=%b exp=1", ir_valid); end
      else begin
         exp_ir = exp_q.pop_front();
         if (ir !== exp_ir) begin failures++; $display("FAIL fetch_ir act=%h exp=%h", ir, exp_ir); end
      end
      checks++; if ({im, nia, branch} !== {8'h34, 1'b1, 1'b0}) begin failures++; $display("FAIL fetch_decode act=%h/%b/%b exp=34/1/0", im, nia, branch); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL hold_mem_req act=%b exp=0", mem_req); end
   endtask

   task automatic test_jump_hold();
      dec_ready = 1'b1; add = 8'h06;
      tick();
      dec_ready = 1'b0;
      checks++; if (pc_en !== 1'b1 || ir_valid !== 1'b0) begin failures++; $display("FAIL accept1 act=%b/%b exp=1/0", pc_en, ir_valid); end
      tick();
      checks++; if (pc_en !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h06) begin failures++; $display("FAIL refetch act=%b/%b/%h exp=0/1/06", pc_en, mem_req, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 16'h4020; exp_q.push_back(16'h4020);
      tick();
      mem_ack = 1'b0;
      wait_ir_valid();
      checks++;
      if (ir_valid !== 1'b1 || exp_q.size() == 0) begin failures++; $display("FAIL jump_ir_valid act=%b exp=1", ir_valid); end
      else begin
         exp_ir = exp_q.pop_front();
         if (ir !== exp_ir) begin failures++; $display("FAIL jump_ir act=%h exp=%h", ir, exp_ir); end
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (ir_valid !== 1'b1 || nia !== 1'b0 || im !== 8'h20 || pc_en !== 1'b0) begin
            failures++; $display("FAIL hold_cycle%0d act=%b/%b/%h/%b exp=1/0/20/0", i, ir_valid, nia, im, pc_en);
         end
      end
      dec_ready = 1'b1; add = 8'h07;
      tick();
      dec_ready = 1'b0;
      checks++; if (pc_en !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL jump_accept act=%b/%b exp=1/0", pc_en, mem_req); end
      tick();
      checks++; if (pc_en !== 1'b0 || mem_req !== 1'b1) begin failures++; $display("FAIL jump_refetch act=%b/%b exp=0/1", pc_en, mem_req); end
   endtask

   task automatic test_branch();
      mem_ack = 1'b1; mem_rdata = 16'h41FE; zflag = 1'b1; exp_q.push_back(16'h41FE);
      tick();
      mem_ack = 1'b0;
      wait_ir_valid();
      checks++;
      if (ir_valid !== 1'b1 || exp_q.size() == 0) begin failures++; $display("FAIL branch_ir_valid act=%b exp=1", ir_valid); end
      else begin
         exp_ir = exp_q.pop_front();
         if (ir !== exp_ir) begin failures++; $display("FAIL branch_ir act=%h exp=%h", ir, exp_ir); end
      end
      checks++; if (branch !== 1'b1 || nia !== 1'b1) begin failures++; $display("FAIL branch_z1 act=%b/%b exp=1/1", branch, nia); end
      zflag = 1'b0;
      #1;
      checks++; if (branch !== 1'b0 || nia !== 1'b1) begin failures++; $display("FAIL branch_z0 act=%b/%b exp=0/1", branch, nia); end
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      // Ack on the terminal-count cycle wins over the timeout.
      for (int i = 0; i < 3; i++) tick();
      mem_ack = 1'b1; mem_rdata = 16'hA55A; exp_q.push_back(16'hA55A);
      tick();
      mem_ack = 1'b0;
      wait_ir_valid();
      checks++;
      if (ir_valid !== 1'b1 || exp_q.size() == 0) begin failures++; $display("FAIL tc_ack_ir_valid act=%b exp=1", ir_valid); end
      else begin
         exp_ir = exp_q.pop_front();
         if (ir !== exp_ir) begin failures++; $display("FAIL tc_ack_ir act=%h exp=%h", ir, exp_ir); end
      end
      checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL tc_ack_fetch_err act=%b exp=0", fetch_err); end
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) tick();
      checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL timeout_early act=%b exp=0", fetch_err); end
      tick();
      checks++; if (fetch_err !== 1'b1 || mem_req !== 1'b1) begin failures++; $display("FAIL timeout_set act=%b/%b exp=1/1", fetch_err, mem_req); end
      tick(); tick();
      mem_ack = 1'b1; mem_rdata = 16'hBEEF; exp_q.push_back(16'hBEEF);
      tick();
      mem_ack = 1'b0;
      wait_ir_valid();
      checks++;
      if (ir_valid !== 1'b1 || exp_q.size() == 0) begin failures++; $display("FAIL timeout_ir_valid act=%b exp=1", ir_valid); end
      else begin
         exp_ir = exp_q.pop_front();
         if (ir !== exp_ir) begin failures++; $display("FAIL timeout_ir act=%h exp=%h", ir, exp_ir); end
      end
      checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky act=%b exp=1", fetch_err); end
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      mem_ack = 1'b1; flush = 1'b1; mem_rdata = 16'hDEAD;
      tick();
      mem_ack = 1'b0; flush = 1'b0;
      checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b1 || ir !== 16'hBEEF) begin failures++; $display("FAIL flush_ack act=%b/%b/%h exp=0/1/beef", ir_valid, mem_req, ir); end
      mem_ack = 1'b1; mem_rdata = 16'h0C0C; exp_q.push_back(16'h0C0C);
      tick();
      mem_ack = 1'b0;
      wait_ir_valid();
      checks++;
      if (ir_valid !== 1'b1 || exp_q.size() == 0) begin failures++; $display("FAIL flush_refetch_valid act=%b exp=1", ir_valid); end
      else begin
         exp_ir = exp_q.pop_front();
         if (ir !== exp_ir) begin failures++; $display("FAIL flush_refetch_ir act=%h exp=%h", ir, exp_ir); end
      end
      dec_ready = 1'b1; flush = 1'b1;
      tick();
      dec_ready = 1'b0; flush = 1'b0;
      checks++; if (pc_en !== 1'b0 || ir_valid !== 1'b0 || mem_req !== 1'b1) begin failures++; $display("FAIL flush_hold act=%b/%b/%b exp=0/0/1", pc_en, ir_valid, mem_req); end
      tick();
      checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL flush_no_pulse act=%b exp=0", pc_en); end
   endtask

   task automatic test_rst_hold();
      mem_ack = 1'b1; mem_rdata = 16'h40AA; exp_q.push_back(16'h40AA);
      tick();
      mem_ack = 1'b0;
      wait_ir_valid();
      checks++;
      if (ir_valid !== 1'b1 || exp_q.size() == 0) begin failures++; $display("FAIL rst_hold_valid act=%b exp=1", ir_valid); end
      else begin
         exp_ir = exp_q.pop_front();
         if (ir !== exp_ir) begin failures++; $display("FAIL rst_hold_ir act=%h exp=%h", ir, exp_ir); end
      end
      rst = 1'b1; dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      checks++;
      if ({mem_req, ir, ir_valid, pc_en, fetch_err, im, nia, branch} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
         failures++; $display("FAIL rst_in_hold act=%b/%h/%b/%b/%b/%h/%b/%b exp=0/0000/0/0/0/00/1/0",
                              mem_req, ir, ir_valid, pc_en, fetch_err, im, nia, branch);
      end
      rst = 1'b0;
      tick();
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_release_req act=%b exp=1", mem_req); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left act=%0d exp=0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_jump_hold();
      test_branch();
      test_timeout();
      test_flush();
      test_rst_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter TIMEOUT, 16, number of FETCH cycles without mem_ack before a timeout; range 2..255.
REQ-002 Parameter JMP_OP, 8'h40, opcode for an unconditional jump.
REQ-003 Parameter BR_OP, 8'h41, opcode for a relative branch taken when zflag=1.
REQ-004 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, synchronous, active-high reset.
REQ-006 Port add, input, 8, current program counter value.
REQ-007 Port mem_req, output, 1, instruction memory read request.
REQ-008 Port mem_addr, output, 8, instruction memory read address.
REQ-009 Port mem_ack, input, 1, memory read data valid.
REQ-010 Port mem_rdata, input, 16, instruction word from memory.
REQ-011 Port dec_ready, input, 1, downstream accepts the held instruction.
REQ-012 Port zflag, input, 1, ALU zero flag used for branch decode.
REQ-013 Port flush, input, 1, abort the current fetch or held instruction.
REQ-014 Port ir, output, 16, instruction register.
REQ-015 Port ir_valid, output, 1, ir holds an unconsumed instruction.
REQ-016 Port pc_en, output, 1, one-cycle pulse that advances the program counter.
REQ-017 Port im, output, 8, immediate field to the program counter.
REQ-018 Port branch, output, 1, relative-branch select to the program counter.
REQ-019 Port nia, output, 1, 0 = absolute jump to im; 1 = sequential or branch.
REQ-020 Port fetch_err, output, 1, sticky memory timeout flag.

Function
REQ-021 The FSM SHALL have four states: IDLE, FETCH, HOLD and SETTLE.
REQ-022 IDLE SHALL go to FETCH unconditionally on the next edge.
REQ-023 mem_req SHALL be 1 exactly while in FETCH, and mem_addr SHALL equal add combinationally.
REQ-024 In FETCH with mem_ack=1, the unit SHALL load ir<=mem_rdata, set ir_valid<=1 and go to HOLD, so ir_valid rises one cycle after the ack.
REQ-025 mem_ack SHALL be ignored outside FETCH.
REQ-026 A wait counter SHALL clear on FETCH entry and increment for each FETCH cycle without ack.
REQ-027 When the wait counter reaches TIMEOUT-1 without ack, the unit SHALL set fetch_err<=1, clear the counter and stay in FETCH to re-issue the request.
REQ-028 If mem_ack arrives on the terminal-count cycle, the ack SHALL win and fetch_err SHALL be unchanged.
REQ-029 In HOLD with dec_ready=1, the unit SHALL set ir_valid<=0 and pc_en<=1 and go to SETTLE.
REQ-030 In HOLD with dec_ready=0, ir and ir_valid SHALL hold.
REQ-031 In SETTLE, the unit SHALL set pc_en<=0 and go to FETCH, so pc_en is exactly one cycle wide and the next request uses the updated add.
REQ-032 flush=1 SHALL take priority over mem_ack, dec_ready and timeout, forcing state<=FETCH, ir_valid<=0, pc_en<=0 and clearing the wait counter.
REQ-033 On flush, ir SHALL keep its value but SHALL be treated as invalid.
REQ-034 Decode SHALL be combinational from ir: im=ir[7:0], nia=(ir[15:8]!=JMP_OP), branch=(ir[15:8]==BR_OP)&zflag.
REQ-035 fetch_err SHALL be cleared only by rst.

Reset
REQ-036 With rst=1 at an edge, the unit SHALL set state=IDLE, ir=16'h0000, ir_valid=0, pc_en=0, fetch_err=0 and wait counter=0.
REQ-037 Consequently, after reset mem_req=0, im=8'h00, nia=1 and branch=0.
REQ-038 rst SHALL override all other inputs in any state, including mid-fetch and in HOLD.
REQ-039 The first mem_req SHALL assert in the second cycle after rst deasserts.

Verification
REQ-040 The bench SHALL cover: reset release, add=8'h05, memory acks after 2 cycles with 16'h1234 -> ir=16'h1234, ir_valid=1, im=8'h34, nia=1, branch=0; mem_addr=8'h05 while mem_req=1.
REQ-041 The bench SHALL cover: ir=16'h4020, dec_ready held low for 5 cycles then high -> ir_valid stays 1 for all 5 cycles, nia=0, im=8'h20, then a single pc_en pulse and mem_req re-asserted 2 cycles after the accept edge.
REQ-042 The bench SHALL cover: ir=16'h41FE with zflag=1 and then zflag=0 -> branch=1 and then branch=0; nia=1 in both cases.
REQ-043 The bench SHALL cover: TIMEOUT=4 with no ack -> fetch_err=1 after 4 FETCH cycles, mem_req remains 1, a later ack loads ir, and fetch_err stays 1.
REQ-044 The bench SHALL cover: flush in the same cycle as mem_ack -> ir_valid stays 0 and the unit re-fetches; flush in HOLD with dec_ready=1 -> no pc_en pulse and ir_valid=0.
REQ-045 The bench SHALL cover: rst asserted in HOLD -> all outputs return to reset values on the next edge.
